// File: rtl/jtexterm_romarb_pkg.sv
// Shared types for the Exterm graphics ROM slot arbiter.
// Fetch FSM states, port indices and starve counter sizing.
package jtexterm_romarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    WAIT
  } state_t;

  localparam int PT_TILE = 0;
  localparam int PT_OBJ  = 1;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtexterm_romarb_port.sv
// Per-port latch: last fetched address/word, ok compare.
// Optional hit cache when JTEXTERM_ROMARB_CACHE_EN is defined.
module jtexterm_romarb_port #(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          ld,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          cld,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          hit
);

  logic [AW-1:0] lat_addr;
  logic          valid;
  logic [DW-1:0] cdata;

  assign ok = cs & valid & (addr == lat_addr);

`ifdef JTEXTERM_ROMARB_CACHE_EN
  logic [AW-1:0] ctag [4];
  logic [DW-1:0] cmem [4];
  logic [3:0]    cval;

  assign hit   = cval[addr[1:0]] & (ctag[addr[1:0]] == addr);
  assign cdata = cmem[addr[1:0]];

  // Every completed SDRAM fetch fills its direct-mapped line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cval <= '0;
    end else if (ld) begin
      cval[ld_addr[1:0]] <= 1'b1;
      ctag[ld_addr[1:0]] <= ld_addr;
      cmem[ld_addr[1:0]] <= ld_data;
    end
  end
`else
  assign hit   = 1'b0;
  assign cdata = data;
`endif

  // Latch returned word from SDRAM or from a cache hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr <= '0;
      data     <= '0;
      valid    <= 1'b0;
    end else if (ld) begin
      lat_addr <= ld_addr;
      data     <= ld_data;
      valid    <= 1'b1;
    end else if (cld) begin
      lat_addr <= addr;
      data     <= cdata;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/jtexterm_romarb.sv
// Tile/object scheduler for the single graphics ROM SDRAM slot.
// Optional per-port hit cache: JTEXTERM_ROMARB_CACHE_EN.
module jtexterm_romarb
  import jtexterm_romarb_pkg::*;
#(
  parameter int AW     = 20,
  parameter int DW     = 32,
  parameter int STARVE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          t_cs,
  input  logic [AW-1:0] t_addr,
  output logic [DW-1:0] t_data,
  output logic          t_ok,
  input  logic          o_cs,
  input  logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  localparam int CW = cnt_w(STARVE);
  localparam logic [CW-1:0] SMAX = CW'(STARVE);

  state_t        st, st_nx;
  logic          own, own_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          cs_nx;
  logic [AW-1:0] addr_nx;
  logic [1:0]    pend, hit, req, ld, cld;
  logic          sel, own_cs;
  logic [AW-1:0] own_addr;

  assign pend     = {o_cs & ~o_ok, t_cs & ~t_ok};
  assign own_cs   = own ? o_cs : t_cs;
  assign own_addr = own ? o_addr : t_addr;

  jtexterm_romarb_port #(.AW(AW), .DW(DW)) u_tile (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (t_cs),
    .addr    (t_addr),
    .ld      (ld[PT_TILE]),
    .ld_addr (rom_addr),
    .ld_data (rom_data),
    .cld     (cld[PT_TILE]),
    .data    (t_data),
    .ok      (t_ok),
    .hit     (hit[PT_TILE])
  );

  jtexterm_romarb_port #(.AW(AW), .DW(DW)) u_obj (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (o_cs),
    .addr    (o_addr),
    .ld      (ld[PT_OBJ]),
    .ld_addr (rom_addr),
    .ld_data (rom_data),
    .cld     (cld[PT_OBJ]),
    .data    (o_data),
    .ok      (o_ok),
    .hit     (hit[PT_OBJ])
  );

  // Grant selection, fetch sequencing and starvation tracking
  always_comb begin
    st_nx   = st;
    own_nx  = own;
    cnt_nx  = cnt;
    cs_nx   = rom_cs;
    addr_nx = rom_addr;
    ld      = '0;
    cld     = '0;
    req     = pend & ~hit;
    sel     = req[PT_OBJ] & (~req[PT_TILE] | (cnt == SMAX));
    if (!pend[PT_OBJ]) cnt_nx = '0;
    unique case (st)
      IDLE: begin
        cld = pend & hit;
        if (|req) begin
          own_nx  = sel;
          addr_nx = sel ? o_addr : t_addr;
          cs_nx   = 1'b1;
          st_nx   = GUARD;
          if (sel)
            cnt_nx = '0;
          else if (pend[PT_OBJ] && cnt != SMAX)
            cnt_nx = cnt + CW'(1);
        end
      end
      GUARD, WAIT: begin
        if (!own_cs) begin
          cs_nx = 1'b0;
          st_nx = IDLE;
        end else if (own_addr != rom_addr) begin
          addr_nx = own_addr;
          st_nx   = GUARD;
        end else if (st == GUARD) begin
          st_nx = WAIT;
        end else if (rom_ok) begin
          ld[own] = 1'b1;
          cs_nx   = 1'b0;
          st_nx   = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      own      <= 1'b0;
      cnt      <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      st       <= st_nx;
      own      <= own_nx;
      cnt      <= cnt_nx;
      rom_cs   <= cs_nx;
      rom_addr <= addr_nx;
    end
  end

endmodule
